memory_writer: RTL and testbench

MEMORY_WRITER -- requirements
Module: memory_writer

---
 rtl/memory_writer.sv | 252 +++++++++++++++++++++++++
 tb/tb_memory_writer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writer.sv
// -----------------------------------------------------------------------------
// memory_writer
//
// Captures one packet from a valid/ready byte stream and stores it in a
// single-port SRAM through the SRAM write side. The memory image is:
//   address 0       : byte count N
//   addresses 1..N  : payload bytes in arrival order
// Each payload byte takes two cycles: one to accept it and one to write it.
// A packet ends on the byte flagged with 'last', or when MAX_LEN bytes have
// arrived. In that second case the packet is truncated and 'overflow' is set.
//
// Parameters
//   DATA_WIDTH : width of stream bytes and SRAM data word (default 8)
//   ADDR_WIDTH : SRAM address width; MAX_LEN = 2**ADDR_WIDTH-1
//
// Ports
//   clk      in   single clock; all state changes on the rising edge
//   resetn   in   asynchronous, active-low reset
//   start    in   level request to capture one packet
//   done     out  packet stored and count written (held until start drops)
//   data_in  in   stream byte
//   valid    in   data_in valid
//   last     in   final byte of the packet (sampled with valid && ready)
//   ready    out  writer can accept a byte this cycle
//   length   out  count word written to address 0, valid while done=1
//   overflow out  packet truncated at MAX_LEN
//   csb0     out  SRAM chip select, active low
//   web0     out  SRAM write enable, active low
//   addr0    out  SRAM address
//   din0     out  SRAM write data
//
// Build option
//   MEMORY_WRITER_MIN_LEN_EN : when defined, packets shorter than 4 bytes are
//   padded with 0x00 up to 4 bytes (one write plus one idle cycle per pad
//   byte) and the count word becomes 4.
// -----------------------------------------------------------------------------
module memory_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  input  logic                  last,
  output logic                  ready,
  output logic [7:0]            length,
  output logic                  overflow,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0
);

  // Largest payload that still leaves address 0 free for the count word.
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = '1;

`ifdef MEMORY_WRITER_MIN_LEN_EN
  localparam logic [ADDR_WIDTH-1:0] MIN_LEN = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    WRITE_COUNT,
    DONE,
    PAD
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    WRITE_COUNT,
    DONE
  } state_e;
`endif

  state_e                  state_q,    state_d;
  logic [ADDR_WIDTH-1:0]   counter_q,  counter_d;
  logic                    end_flag_q, end_flag_d;
  logic                    ready_q,    ready_d;
  logic                    done_q,     done_d;
  logic [7:0]              length_q,   length_d;
  logic                    overflow_q, overflow_d;
  logic                    csb0_q,     csb0_d;
  logic                    web0_q,     web0_d;
  logic [ADDR_WIDTH-1:0]   addr0_q,    addr0_d;
  logic [DATA_WIDTH-1:0]   din0_q,     din0_d;

  logic [ADDR_WIDTH-1:0]   counter_inc;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    counter_d   = counter_q;
    end_flag_d  = end_flag_q;
    ready_d     = ready_q;
    done_d      = done_q;
    length_d    = length_q;
    overflow_d  = overflow_q;
    csb0_d      = csb0_q;
    web0_d      = web0_q;
    addr0_d     = addr0_q;
    din0_d      = din0_q;

    counter_inc = counter_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        csb0_d  = 1'b1;
        web0_d  = 1'b1;
        done_d  = 1'b0;
        // overflow from the previous packet stays visible until a new start.
        if (start) begin
          state_d    = RECV;
          counter_d  = '0;
          end_flag_d = 1'b0;
          ready_d    = 1'b1;
          overflow_d = 1'b0;
        end
      end

      RECV: begin
        // Without valid the state simply holds with ready high; a lone
        // 'last' is meaningless and ignored.
        if (valid && ready_q) begin
          csb0_d     = 1'b0;
          web0_d     = 1'b0;
          addr0_d    = counter_inc;
          din0_d     = data_in;
          counter_d  = counter_inc;
          ready_d    = 1'b0;
          end_flag_d = last || (counter_inc == MAX_LEN);
          // Reaching the size limit without 'last' means the packet is cut.
          overflow_d = (counter_inc == MAX_LEN) && !last;
          state_d    = WRITE;
        end
      end

      WRITE: begin
        // The SRAM samples the payload write at the edge closing this cycle.
        csb0_d = 1'b1;
        web0_d = 1'b1;
        if (!end_flag_q) begin
          ready_d = 1'b1;
          state_d = RECV;
        end
`ifdef MEMORY_WRITER_MIN_LEN_EN
        else if (counter_q < MIN_LEN) begin
          // Short packet: leave an idle cycle, then emit a pad byte.
          state_d = PAD;
        end
`endif
        else begin
          // Count word goes out on the very next cycle.
          csb0_d  = 1'b0;
          web0_d  = 1'b0;
          addr0_d = '0;
          din0_d  = DATA_WIDTH'(counter_q);
          state_d = WRITE_COUNT;
        end
      end

`ifdef MEMORY_WRITER_MIN_LEN_EN
      PAD: begin
        // One zero byte per visit; WRITE then decides whether more are needed.
        csb0_d    = 1'b0;
        web0_d    = 1'b0;
        addr0_d   = counter_inc;
        din0_d    = '0;
        counter_d = counter_inc;
        state_d   = WRITE;
      end
`endif

      WRITE_COUNT: begin
        csb0_d   = 1'b1;
        web0_d   = 1'b1;
        done_d   = 1'b1;
        length_d = 8'(counter_q);
        state_d  = DONE;
      end

      DONE: begin
        // Stay here while start is still high so one request means one packet.
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        ready_d = 1'b0;
        csb0_d  = 1'b1;
        web0_d  = 1'b1;
        done_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      end_flag_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      length_q   <= '0;
      overflow_q <= 1'b0;
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      addr0_q    <= '0;
      din0_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register updates from the
      // values present before the edge, independent of statement order.
      state_q    <= state_d;
      counter_q  <= counter_d;
      end_flag_q <= end_flag_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      length_q   <= length_d;
      overflow_q <= overflow_d;
      csb0_q     <= csb0_d;
      web0_q     <= web0_d;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
    end
  end

  assign done     = done_q;
  assign ready    = ready_q;
  assign length   = length_q;
  assign overflow = overflow_q;
  assign csb0     = csb0_q;
  assign web0     = web0_q;
  assign addr0    = addr0_q;
  assign din0     = din0_q;

endmodule

// File: tb/tb_memory_writer.sv
// -----------------------------------------------------------------------------
// tb_memory_writer
//
// Table-driven bench for memory_writer. Each table row describes one packet
// (payload pattern, use of last, valid gaps, how long start is held after
// done) with its hand-computed count word and overflow flag. A behavioural
// SRAM captures every write so that the stored image can be compared against
// the expected image. Mid-packet reset and the reset state are hand-written
// sequences.
// -----------------------------------------------------------------------------
module tb_memory_writer;

  localparam int DW = 8;
  localparam int AW = 8;

`ifdef MEMORY_WRITER_MIN_LEN_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          resetn  = 1'b1;
  logic          start   = 1'b0;
  logic          valid   = 1'b0;
  logic          last    = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          done;
  logic          ready;
  logic [7:0]    length;
  logic          overflow;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;

  always #5 clk = ~clk;

  memory_writer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .done     (done),
    .data_in  (data_in),
    .valid    (valid),
    .last     (last),
    .ready    (ready),
    .length   (length),
    .overflow (overflow),
    .csb0     (csb0),
    .web0     (web0),
    .addr0    (addr0),
    .din0     (din0)
  );

  // Behavioural SRAM write port plus write statistics.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int writes       = 0;
  int addr0_writes = 0;
  int proto_err    = 0;

  always @(posedge clk) begin
    if (csb0 === 1'b0 && web0 === 1'b0) begin
      mem[addr0] <= din0;
      writes     <= writes + 1;
      if (addr0 == '0) addr0_writes <= addr0_writes + 1;
    end
    // Write enable must never be active without chip select.
    if (web0 === 1'b0 && csb0 !== 1'b0) proto_err <= proto_err + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] base;       // payload byte i = base + i*step
    logic [7:0] step;
    int         n;          // bytes offered
    bit         use_last;   // last flagged on byte n-1
    bit         hold_valid; // keep valid high between and after bytes
    int         max_gap;    // random idle cycles (valid low) before a byte
    int         hold_done;  // cycles start stays high after done
    int         exp_len;    // count word without padding
    bit         exp_ovf;
  } vec_t;

  // Present one byte and wait (bounded) until it is accepted. Called and
  // returns at a falling edge. During a gap, valid is low while last is high
  // and start is dropped, all of which the writer must ignore.
  task automatic push(input logic [7:0] d, input logic l, input int gap, output bit ok);
    ok = 1'b0;
    if (gap > 0) begin
      valid   = 1'b0;
      last    = 1'b1;
      data_in = 8'hC3;
      start   = 1'b0;
      repeat (gap) @(negedge clk);
      start   = 1'b1;
    end
    data_in = d;
    last    = l;
    valid   = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_packet(input vec_t v);
    int         w0;
    int         a0;
    int         exp_len;
    int         bad;
    int         t;
    bit         ok;
    logic [7:0] b;
    logic [7:0] exp_b;

    exp_len = v.exp_len;
    if (PAD_EN && exp_len < 4) exp_len = 4;
    w0 = writes;
    a0 = addr0_writes;

    start = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      b = v.base + 8'(i) * v.step;
      push(b, v.use_last && (i == v.n - 1),
           (v.max_gap > 0) ? int'($urandom_range(0, v.max_gap)) : 0, ok);
      check({v.name, " accept"}, 32'(ok), 1);
      if (!ok) break;
      if (!v.hold_valid) valid = 1'b0;
    end
    // Further offered bytes must be refused once the packet has ended.
    valid   = v.hold_valid;
    data_in = 8'hEE;
    last    = 1'b0;

    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({v.name, " done"},     32'(done),     1);
    check({v.name, " length"},   32'(length),   32'(exp_len));
    check({v.name, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
    check({v.name, " ready"},    32'(ready),    0);
    check({v.name, " writes"},   32'(writes - w0),       32'(exp_len + 1));
    check({v.name, " count wr"}, 32'(addr0_writes - a0), 1);
    check({v.name, " sram0"},    32'(mem[0]),   32'(exp_len));

    bad = 0;
    for (int i = 0; i < exp_len; i++) begin
      exp_b = (i < v.n) ? v.base + 8'(i) * v.step : 8'h00;
      if (mem[i+1] !== exp_b) bad++;
    end
    check({v.name, " payload bad bytes"}, 32'(bad), 0);
    valid = 1'b0;

    if (v.hold_done > 0) begin
      w0 = writes;
      repeat (v.hold_done) @(negedge clk);
      check({v.name, " done held"},   32'(done),        1);
      check({v.name, " no new pkt"},  32'(writes - w0), 0);
      check({v.name, " ready held"},  32'(ready),       0);
    end

    start = 1'b0;
    @(negedge clk);
    check({v.name, " done drop"}, 32'(done),     0);
    check({v.name, " ovf kept"},  32'(overflow), 32'(v.exp_ovf));
    @(negedge clk);
  endtask

  vec_t vecs [5];
  vec_t rvec;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int a0;

    //            name        base   step   n    last hold gap hold_done len ovf
    vecs[0] = '{"three",     8'h11, 8'h11, 3,   1,   1,   0,  0,        3,  0};
    vecs[1] = '{"overflow",  8'h01, 8'h01, 255, 0,   1,   0,  0,        255,1};
    vecs[2] = '{"single",    8'hA5, 8'h00, 1,   1,   1,   0,  0,        1,  0};
    vecs[3] = '{"gaps",      8'h40, 8'h07, 6,   1,   0,   3,  0,        6,  0};
    vecs[4] = '{"hold_start",8'h90, 8'h10, 5,   1,   1,   0,  4,        5,  0};
    rvec    = '{"after_rst", 8'h61, 8'h03, 5,   1,   0,   1,  0,        5,  0};

    // Reset state.
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst done",     32'(done),     0);
    check("rst ready",    32'(ready),    0);
    check("rst overflow", 32'(overflow), 0);
    check("rst length",   32'(length),   0);
    check("rst csb0",     32'(csb0),     1);
    check("rst web0",     32'(web0),     1);
    check("rst addr0",    32'(addr0),    0);
    check("rst din0",     32'(din0),     0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle ready", 32'(ready), 0);

    foreach (vecs[k]) run_packet(vecs[k]);

    // Reset after two bytes of five: outputs clear at once, no count word.
    a0    = addr0_writes;
    start = 1'b1;
    push(8'h51, 1'b0, 0, ok);
    check("mid accept 1", 32'(ok), 1);
    push(8'h52, 1'b0, 0, ok);
    check("mid accept 2", 32'(ok), 1);
    data_in = 8'h53;
    resetn  = 1'b0;
    #1;
    check("mid rst csb0",   32'(csb0),   1);
    check("mid rst web0",   32'(web0),   1);
    check("mid rst ready",  32'(ready),  0);
    check("mid rst done",   32'(done),   0);
    check("mid rst addr0",  32'(addr0),  0);
    check("mid rst din0",   32'(din0),   0);
    check("mid rst length", 32'(length), 0);
    repeat (2) @(negedge clk);
    valid = 1'b0;
    check("mid rst no count wr", 32'(addr0_writes - a0), 0);
    check("mid rst byte1 kept",  32'(mem[1]), 32'h51);
    // Release with start still high: a new packet begins.
    resetn = 1'b1;
    run_packet(rvec);

    check("csb/web protocol", 32'(proto_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
